histogram_accumulator: RTL and testbench



---
 rtl/hist_pkg.sv | 20 ++
 rtl/hist_bank_ram.sv | 22 ++
 rtl/histogram_accumulator.sv | 187 ++++++++++++++++++
 tb/tb_histogram_accumulator.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hist_pkg.sv
// Shared constants, FSM state type and the saturating counter increment
// used by the histogram accumulator.
package hist_pkg;

   localparam int PIX_W = 8;
   localparam int CNT_W = 20;
   localparam int BINS  = 1 << PIX_W;

   typedef enum logic [1:0] {
      CLEAR,
      ACCUM,
      DRAIN
   } state_e;

   // Width-agnostic so that narrower counter builds share the same helper.
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
      return (v >= max_v) ? max_v : v + 32'd1;
   endfunction

endpackage

// File: rtl/hist_bank_ram.sv
// Simple dual-port histogram bank: one write port, one read port with a
// registered (read-first) output.
module hist_bank_ram #(
   parameter int AW = 8,
   parameter int DW = 20
) (
   input  logic          clk,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data
);

   logic [DW-1:0] mem_q [1<<AW];

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_addr] <= wr_data;
      rd_data <= mem_q[rd_addr];
   end

endmodule

// File: rtl/histogram_accumulator.sv
// Ping-pong pixel histogram: bins one frame into the accumulate bank while
// the display bank is read out, then swaps banks and publishes the peak.
//
//   state | meaning
//   CLEAR | zero accumulate bank (both banks after reset), pixels dropped
//   ACCUM | 3-stage read-modify-write of incoming pixels
//   DRAIN | 2 cycles for the S1/S2 stages to retire, then swap banks
module histogram_accumulator #(
   parameter int BINS  = hist_pkg::BINS,
   parameter int PIX_W = hist_pkg::PIX_W,
   parameter int CNT_W = hist_pkg::CNT_W
) (
   input  logic             iClk,
   input  logic             iRst_n,
   input  logic             iValid,
   input  logic [PIX_W-1:0] iPixel,
   input  logic             iFrameEnd,
   input  logic [PIX_W-1:0] iRdAddr,
   output logic [CNT_W-1:0] oRdData,
   output logic [CNT_W-1:0] oMaxValue,
   output logic             oFrameDone,
   output logic             oBusy,
   output logic             oOverrun
);
   import hist_pkg::*;

   localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

   state_e           state_q, state_d;
   logic [PIX_W-1:0] clr_addr_q, clr_addr_d;
   logic             both_q, both_d;
   logic             acc_sel_q, acc_sel_d;
   logic             drain_cnt_q, drain_cnt_d;
   logic             s1_vld_q, s1_vld_d;
   logic [PIX_W-1:0] s1_addr_q, s1_addr_d;
   logic             s1_fwd_q, s1_fwd_d;
   logic [CNT_W-1:0] s1_fwd_val_q, s1_fwd_val_d;
   logic             s2_vld_q, s2_vld_d;
   logic [PIX_W-1:0] s2_addr_q, s2_addr_d;
   logic [CNT_W-1:0] s2_val_q, s2_val_d;
   logic [CNT_W-1:0] run_max_q, run_max_d;
   logic [CNT_W-1:0] max_val_q, max_val_d;
   logic             frame_done_q, frame_done_d;
   logic             disp_sel_q, disp_sel_d;
   logic             rd_vld_q, rd_vld_d;

   logic             busy, s0_vld;
   logic [CNT_W-1:0] acc_rdat, s1_cnt, s1_new, run_max_upd;
   logic             acc_we, disp_we;
   logic [PIX_W-1:0] acc_waddr;
   logic [CNT_W-1:0] acc_wdata;
   logic             we0, we1;
   logic [PIX_W-1:0] rd_addr0, rd_addr1, wr_addr0, wr_addr1;
   logic [CNT_W-1:0] wdat0, wdat1, rdat0, rdat1;

   always_comb begin
      busy     = (state_q != ACCUM);
      s0_vld   = iValid && !busy;
      acc_rdat = acc_sel_q ? rdat1 : rdat0;
      // Newest in-flight value wins: S2 now, else the S2 write the S0 read missed.
      if (s2_vld_q && (s2_addr_q == s1_addr_q)) s1_cnt = s2_val_q;
      else if (s1_fwd_q)                        s1_cnt = s1_fwd_val_q;
      else                                      s1_cnt = acc_rdat;
      s1_new      = CNT_W'(sat_inc(32'(s1_cnt), CNT_MAX));
      run_max_upd = (s2_vld_q && (s2_val_q > run_max_q)) ? s2_val_q : run_max_q;

      acc_we    = (state_q == CLEAR) || s2_vld_q;
      acc_waddr = (state_q == CLEAR) ? clr_addr_q : s2_addr_q;
      acc_wdata = (state_q == CLEAR) ? '0 : s2_val_q;
      disp_we   = (state_q == CLEAR) && both_q;

      we0      = acc_sel_q ? disp_we    : acc_we;
      wr_addr0 = acc_sel_q ? clr_addr_q : acc_waddr;
      wdat0    = acc_sel_q ? '0         : acc_wdata;
      rd_addr0 = acc_sel_q ? iRdAddr    : iPixel;
      we1      = acc_sel_q ? acc_we     : disp_we;
      wr_addr1 = acc_sel_q ? acc_waddr  : clr_addr_q;
      wdat1    = acc_sel_q ? acc_wdata  : '0;
      rd_addr1 = acc_sel_q ? iPixel     : iRdAddr;
   end

   always_comb begin
      state_d      = state_q;
      clr_addr_d   = clr_addr_q;
      both_d       = both_q;
      acc_sel_d    = acc_sel_q;
      drain_cnt_d  = drain_cnt_q;
      run_max_d    = run_max_upd;
      max_val_d    = max_val_q;
      frame_done_d = 1'b0;
      case (state_q)
         CLEAR: begin
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == PIX_W'(BINS - 1)) begin
               state_d    = ACCUM;
               both_d     = 1'b0;
               clr_addr_d = '0;
            end
         end
         ACCUM: begin
            if (iFrameEnd) begin
               state_d     = DRAIN;
               drain_cnt_d = 1'b1;
            end
         end
         DRAIN: begin
            drain_cnt_d = 1'b0;
            if (!drain_cnt_q) begin
               state_d      = CLEAR;
               both_d       = 1'b0;
               max_val_d    = run_max_upd;
               run_max_d    = '0;
               acc_sel_d    = ~acc_sel_q;
               frame_done_d = 1'b1;
            end
         end
         default: state_d = CLEAR;
      endcase

      s1_vld_d     = s0_vld;
      s1_addr_d    = iPixel;
      s1_fwd_d     = s0_vld && s2_vld_q && (iPixel == s2_addr_q);
      s1_fwd_val_d = s2_val_q;
      s2_vld_d     = s1_vld_q;
      s2_addr_d    = s1_addr_q;
      s2_val_d     = s1_new;
      disp_sel_d   = ~acc_sel_q;
      rd_vld_d     = 1'b1;
   end

   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         state_q      <= CLEAR;
         clr_addr_q   <= '0;
         both_q       <= 1'b1;
         acc_sel_q    <= 1'b0;
         drain_cnt_q  <= 1'b0;
         s1_vld_q     <= 1'b0;
         s1_addr_q    <= '0;
         s1_fwd_q     <= 1'b0;
         s1_fwd_val_q <= '0;
         s2_vld_q     <= 1'b0;
         s2_addr_q    <= '0;
         s2_val_q     <= '0;
         run_max_q    <= '0;
         max_val_q    <= '0;
         frame_done_q <= 1'b0;
         disp_sel_q   <= 1'b1;
         rd_vld_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         clr_addr_q   <= clr_addr_d;
         both_q       <= both_d;
         acc_sel_q    <= acc_sel_d;
         drain_cnt_q  <= drain_cnt_d;
         s1_vld_q     <= s1_vld_d;
         s1_addr_q    <= s1_addr_d;
         s1_fwd_q     <= s1_fwd_d;
         s1_fwd_val_q <= s1_fwd_val_d;
         s2_vld_q     <= s2_vld_d;
         s2_addr_q    <= s2_addr_d;
         s2_val_q     <= s2_val_d;
         run_max_q    <= run_max_d;
         max_val_q    <= max_val_d;
         frame_done_q <= frame_done_d;
         disp_sel_q   <= disp_sel_d;
         rd_vld_q     <= rd_vld_d;
      end
   end

   hist_bank_ram #(.AW(PIX_W), .DW(CNT_W)) u_bank0 (
      .clk(iClk), .rd_addr(rd_addr0), .rd_data(rdat0),
      .wr_en(we0), .wr_addr(wr_addr0), .wr_data(wdat0)
   );

   hist_bank_ram #(.AW(PIX_W), .DW(CNT_W)) u_bank1 (
      .clk(iClk), .rd_addr(rd_addr1), .rd_data(rdat1),
      .wr_en(we1), .wr_addr(wr_addr1), .wr_data(wdat1)
   );

   assign oRdData    = rd_vld_q ? (disp_sel_q ? rdat1 : rdat0) : '0;
   assign oMaxValue  = max_val_q;
   assign oFrameDone = frame_done_q;
   assign oBusy      = busy;
   assign oOverrun   = iRst_n && iValid && busy;

endmodule

// File: tb/tb_histogram_accumulator.sv
// Randomised bench for histogram_accumulator: a 20-bit and a 4-bit counter
// build share one stimulus and are checked every cycle against an array model.
module tb_histogram_accumulator;

   logic        clk = 1'b0;
   logic        rst_n, valid, fe;
   logic [7:0]  pixel, rd_addr;
   logic [19:0] rd_b, max_b;
   logic [3:0]  rd_s, max_s;
   logic        fd_b, fd_s, busy_b, busy_s, ovr_b, ovr_s;

   int n_tests = 0;
   int n_fail  = 0;
   int ovr_cnt = 0;

   initial forever #5 clk = ~clk;

   histogram_accumulator u_big (
      .iClk(clk), .iRst_n(rst_n), .iValid(valid), .iPixel(pixel), .iFrameEnd(fe),
      .iRdAddr(rd_addr), .oRdData(rd_b), .oMaxValue(max_b), .oFrameDone(fd_b),
      .oBusy(busy_b), .oOverrun(ovr_b)
   );

   histogram_accumulator #(.CNT_W(4)) u_small (
      .iClk(clk), .iRst_n(rst_n), .iValid(valid), .iPixel(pixel), .iFrameEnd(fe),
      .iRdAddr(rd_addr), .oRdData(rd_s), .oMaxValue(max_s), .oFrameDone(fd_s),
      .oBusy(busy_s), .oOverrun(ovr_s)
   );

   // Model: per-build accumulate/display histograms plus a busy-cycle timeline.
   int unsigned acc  [2][256];
   int unsigned disp [2][256];
   int unsigned cmax [2] = '{32'h000F_FFFF, 32'd15};
   int unsigned exp_max [2];
   int unsigned exp_rd  [2];
   bit exp_fd, rd_chk, disp_valid, rst_clear, chk_en;
   int busy_left;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_step();
      int unsigned mx;
      if (!rst_n) begin
         busy_left  = 256;
         rst_clear  = 1'b1;
         disp_valid = 1'b0;
         exp_fd     = 1'b0;
         rd_chk     = 1'b1;
         for (int d = 0; d < 2; d++) begin
            exp_rd[d]  = 0;
            exp_max[d] = 0;
            for (int b = 0; b < 256; b++) begin
               acc[d][b]  = 0;
               disp[d][b] = 0;
            end
         end
         chk_en = 1'b1;
      end else begin
         rd_chk = disp_valid;
         for (int d = 0; d < 2; d++) exp_rd[d] = disp[d][rd_addr];
         exp_fd = 1'b0;
         if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 256) begin
               exp_fd = 1'b1;
               for (int d = 0; d < 2; d++) begin
                  mx = 0;
                  for (int b = 0; b < 256; b++) begin
                     disp[d][b] = acc[d][b];
                     if (acc[d][b] > mx) mx = acc[d][b];
                     acc[d][b] = 0;
                  end
                  exp_max[d] = mx;
               end
            end
            if (busy_left == 0 && rst_clear) begin
               disp_valid = 1'b1;
               rst_clear  = 1'b0;
            end
         end else begin
            if (valid)
               for (int d = 0; d < 2; d++)
                  if (acc[d][pixel] < cmax[d]) acc[d][pixel]++;
            if (fe) busy_left = 258;
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      bit eb;
      @(negedge clk);
      if (chk_en) begin
         eb = (busy_left > 0);
         check("busy",         busy_b, eb);
         check("busy_s",       busy_s, eb);
         check("overrun",      ovr_b,  rst_n && valid && eb);
         check("overrun_s",    ovr_s,  rst_n && valid && eb);
         check("frame_done",   fd_b,   exp_fd);
         check("frame_done_s", fd_s,   exp_fd);
         check("max",          max_b,  exp_max[0]);
         check("max_s",        max_s,  exp_max[1]);
         if (rd_chk) begin
            check("rd_data",   rd_b, exp_rd[0]);
            check("rd_data_s", rd_s, exp_rd[1]);
         end
         if (ovr_b) ovr_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic px(input logic v, input logic [7:0] p, input logic e);
      valid = v;
      pixel = p;
      fe    = e;
      tick();
   endtask

   task automatic idle_inputs();
      valid = 1'b0;
      pixel = 8'd0;
      fe    = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy_b && n < 600) begin
         tick();
         n++;
      end
      check("idle_timeout", busy_b, 1'b0);
   endtask

   task automatic wait_fd();
      int n = 0;
      idle_inputs();
      while (!fd_b && n < 600) begin
         tick();
         n++;
      end
      check("frame_done_timeout", fd_b, 1'b1);
   endtask

   task automatic count_busy();
      int n = 0;
      while (busy_b && n < 1000) begin
         n++;
         tick();
      end
      check("busy_cycles", n, 256);
   endtask

   task automatic sweep_reads();
      for (int a = 0; a < 256; a++) begin
         rd_addr = 8'(a);
         tick();
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      rd_addr = 8'd0;
      idle_inputs();
      repeat (3) tick();
      rst_n = 1'b1;
      count_busy();
      sweep_reads();
      check("reset_max", max_b, 0);

      // Back-to-back identical pixels exercise both forwarding paths.
      for (int i = 0; i < 4; i++) px(1'b1, 8'd5, 1'b0);
      px(1'b1, 8'd9, 1'b0);
      px(1'b0, 8'd0, 1'b1);
      wait_fd();
      check("f1_max",   max_b, 4);
      check("f1_max_s", max_s, 4);
      rd_addr = 8'd5;
      tick();
      check("f1_bin5", rd_b, 4);
      rd_addr = 8'd9;
      tick();
      check("f1_bin9", rd_b, 1);
      sweep_reads();

      // Bin 5 stays on display while the next frame accumulates.
      rd_addr = 8'd5;
      wait_idle();
      for (int i = 0; i < 3; i++) px(1'b1, 8'd200, 1'b0);
      check("f2_bin5_before", rd_b, 4);
      px(1'b0, 8'd0, 1'b1);
      wait_fd();
      check("f2_max", max_b, 3);
      tick();
      check("f2_bin5_after", rd_b, 0);
      rd_addr = 8'd200;
      tick();
      check("f2_bin200", rd_b, 3);

      wait_idle();
      for (int i = 0; i < 200; i++) px(1'b1, (i % 2 == 0) ? 8'd7 : 8'd8, (i == 199));
      wait_fd();
      check("f3_max",   max_b, 100);
      check("f3_max_s", max_s, 15);
      sweep_reads();

      // Pixels and stray frame ends offered throughout DRAIN/CLEAR.
      wait_idle();
      for (int i = 0; i < 10; i++) px(1'b1, 8'($urandom_range(0, 15)), 1'b0);
      px(1'b1, 8'd33, 1'b1);
      ovr_cnt = 0;
      for (int i = 0; i < 258; i++) px(1'b1, 8'($urandom), ($urandom_range(0, 7) == 0));
      idle_inputs();
      check("overrun_count", ovr_cnt, 258);
      check("busy_after_overrun", busy_b, 1'b0);
      for (int i = 0; i < 40; i++) px(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 1'b0);
      px(1'b0, 8'd0, 1'b1);
      wait_fd();
      sweep_reads();

      for (int f = 0; f < 4; f++) begin
         int len;
         bit narrow;
         wait_idle();
         len    = $urandom_range(20, 300);
         narrow = ($urandom_range(0, 1) == 1);
         for (int i = 0; i < len; i++) begin
            rd_addr = 8'($urandom);
            px(1'($urandom_range(0, 1)),
               narrow ? 8'($urandom_range(0, 3)) : 8'($urandom), (i == len - 1));
         end
         wait_fd();
         sweep_reads();
      end

      wait_idle();
      for (int i = 0; i < 19; i++) px(1'b1, 8'd42, 1'b0);
      px(1'b0, 8'd0, 1'b1);
      wait_fd();
      check("sat_max",   max_b, 19);
      check("sat_max_s", max_s, 15);
      rd_addr = 8'd42;
      tick();
      check("sat_bin",   rd_b, 19);
      check("sat_bin_s", rd_s, 15);

      // Reset in the middle of a frame discards everything.
      wait_idle();
      for (int i = 0; i < 5; i++) px(1'b1, 8'd77, 1'b0);
      rst_n = 1'b0;
      px(1'b1, 8'd77, 1'b0);
      rst_n = 1'b1;
      idle_inputs();
      count_busy();
      check("rst_max", max_b, 0);
      sweep_reads();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
